// File: rtl/taxi_fare_pkg.sv
// Shared constants and helpers for the taxi fare meter blocks.
package taxi_fare_pkg;

  // Default minutes per waiting-fare unit.
  localparam int unsigned WAIT_MIN_DEFAULT = 5;
  // Default free waiting minutes after reset (free-minute builds only).
  localparam int unsigned FREE_MIN_DEFAULT = 3;

  // Counter width for a modulo-n counter: max(1, clog2(n)).
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 32'($clog2(n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Generic modulo-N counter with a combinational wrap strobe.
// Counts 0..N-1 while en is high and holds otherwise. wrap_c is high in the
// cycle whose edge takes the counter from N-1 back to 0. Any code above N-1
// (unreachable in normal operation) returns to 0 on the next enabled edge
// without a wrap strobe.
module mod_n_counter
  import taxi_fare_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap_c
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  // Wrap strobe: enabled edge arriving while sitting on the last code.
  assign wrap_c = en && (cnt == LAST);

  // Counter state; out-of-range codes collapse to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/wait_fare_count.sv
// Waiting-time fare generator: one wait_fare_pulse every WAIT_MIN minutes.
// Clocked by the one-pulse-per-minute timebase (min_pulse).
// Optional build macro WAIT_FREE_MINUTES_EN: the first FREE_MIN minutes after
// reset are free; the minute counter holds at 0 until they have elapsed.
module wait_fare_count
  import taxi_fare_pkg::*;
#(
  parameter int unsigned WAIT_MIN = WAIT_MIN_DEFAULT,
  parameter int unsigned FREE_MIN = FREE_MIN_DEFAULT
) (
  input  logic min_pulse,
  input  logic rst_n,
  output logic wait_fare_pulse
);

  localparam int unsigned CNT_W = cnt_width(WAIT_MIN);

  logic count_en;
  logic min_wrap_c;

`ifdef WAIT_FREE_MINUTES_EN
  if (FREE_MIN == 0) begin : g_no_free
    // Zero free minutes: charge from the first minute.
    assign count_en = 1'b1;
  end else begin : g_free
    localparam int unsigned FREE_W = cnt_width(FREE_MIN + 1);

    logic free_wrap_c;
    logic free_done;

    mod_n_counter #(
      .N (FREE_MIN),
      .W (FREE_W)
    ) u_free_cnt (
      .clk    (min_pulse),
      .rst_n  (rst_n),
      .en     (~free_done),
      .wrap_c (free_wrap_c)
    );

    // Latches once the free period has been used up; cleared only by reset.
    always_ff @(posedge min_pulse or negedge rst_n) begin
      if (!rst_n) begin
        free_done <= 1'b0;
      end else if (free_wrap_c) begin
        free_done <= 1'b1;
      end
    end

    assign count_en = free_done;
  end
`else
  // No free period in this build; FREE_MIN has no effect.
  if (FREE_MIN != 0) begin : g_free_min_ignored
  end
  assign count_en = 1'b1;
`endif

  mod_n_counter #(
    .N (WAIT_MIN),
    .W (CNT_W)
  ) u_min_cnt (
    .clk    (min_pulse),
    .rst_n  (rst_n),
    .en     (count_en),
    .wrap_c (min_wrap_c)
  );

  // Register the wrap strobe so the fare pulse has no input-to-output path.
  always_ff @(posedge min_pulse or negedge rst_n) begin
    if (!rst_n) begin
      wait_fare_pulse <= 1'b0;
    end else begin
      wait_fare_pulse <= min_wrap_c;
    end
  end

endmodule

// File: tb/tb_wait_fare_count.sv
// Directed bench for wait_fare_count at WAIT_MIN = 5, 1 and 7.
module tb_wait_fare_count;

`ifdef WAIT_FREE_MINUTES_EN
  localparam int F = 3;
`else
  localparam int F = 0;
`endif

  logic min_pulse = 1'b0;
  logic rst_n     = 1'b0;
  logic p5, p1, p7;

  wait_fare_count #(.WAIT_MIN(5), .FREE_MIN(3)) dut5 (
    .min_pulse(min_pulse), .rst_n(rst_n), .wait_fare_pulse(p5));
  wait_fare_count #(.WAIT_MIN(1), .FREE_MIN(3)) dut1 (
    .min_pulse(min_pulse), .rst_n(rst_n), .wait_fare_pulse(p1));
  wait_fare_count #(.WAIT_MIN(7), .FREE_MIN(3)) dut7 (
    .min_pulse(min_pulse), .rst_n(rst_n), .wait_fare_pulse(p7));

  always #10 min_pulse = ~min_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic rst;
    logic e5;
    logic e1;
    logic e7;
    int   c5;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic int cnt5();
    return int'(dut5.u_min_cnt.cnt);
  endfunction

  function automatic int cnt7();
    return int'(dut7.u_min_cnt.cnt);
  endfunction

  initial begin
    int pulses5;
    int pulses7_70;
    int n;

`ifdef WAIT_FREE_MINUTES_EN
    // rst, p5, p1, p7, cnt5 after each edge (3 free minutes first)
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
`else
    // rst, p5, p1, p7, cnt5 after each edge
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 3});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 0});
`endif

    // Reset state
    #5;
    check("reset_p5", int'(p5), 0);
    check("reset_p1", int'(p1), 0);
    check("reset_cnt5", cnt5(), 0);

    // Reset held across 500 edges
    for (int i = 0; i < 500; i++) begin
      @(posedge min_pulse); #1;
      check("hold_p5", int'(p5), 0);
      check("hold_p1", int'(p1), 0);
      check("hold_cnt5", cnt5(), 0);
    end

    // Table: reset level set at the falling edge, outputs sampled after the rising edge
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge min_pulse);
      rst_n = tbl[i].rst;
      @(posedge min_pulse); #1;
      check($sformatf("row%0d_p5", i), int'(p5), int'(tbl[i].e5));
      check($sformatf("row%0d_p1", i), int'(p1), int'(tbl[i].e1));
      check($sformatf("row%0d_p7", i), int'(p7), int'(tbl[i].e7));
      check($sformatf("row%0d_cnt5", i), cnt5(), tbl[i].c5);
    end

    // Steady run of 5000 edges from a fresh release
    @(negedge min_pulse); rst_n = 1'b0;
    @(negedge min_pulse); rst_n = 1'b1;
    pulses5 = 0;
    pulses7_70 = 0;
    for (int e = 1; e <= 5000; e++) begin
      @(posedge min_pulse); #1;
      n = e - F;
      check("run_p5", int'(p5), (n > 0 && n % 5 == 0) ? 1 : 0);
      check("run_p1", int'(p1), (n > 0) ? 1 : 0);
      check("run_p7", int'(p7), (n > 0 && n % 7 == 0) ? 1 : 0);
      check("run_cnt7_range", (cnt7() < 7) ? 1 : 0, 1);
      if (p5) pulses5++;
      if (p7 && e <= 70) pulses7_70++;
    end
    check("run_pulses5", pulses5, (5000 - F) / 5);
    check("run_pulses7_70", pulses7_70, (70 - F) / 7);

    // Asynchronous drop of a high pulse between edges
    @(negedge min_pulse); rst_n = 1'b0;
    @(negedge min_pulse); rst_n = 1'b1;
    repeat (F + 5) @(posedge min_pulse);
    #1;
    check("drop_pre_p5", int'(p5), 1);
    check("drop_pre_p1", int'(p1), 1);
    #5 rst_n = 1'b0;
    #1;
    check("drop_post_p5", int'(p5), 0);
    check("drop_post_p1", int'(p1), 0);
    check("drop_post_cnt5", cnt5(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
